drop_gate: RTL



---
 rtl/drop_gate.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/drop_gate.sv
`default_nettype none
// ----------------------------------------------------------------------------
// drop_gate : discards whole packets whose masked drop causes are set, forwards
// the rest on a registered stream. Optional macro DROP_GATE_PER_CAUSE_CNT_EN.
// Revision : 1.0
// ----------------------------------------------------------------------------
module drop_gate #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_CAUSES           = 5
) (
  input  logic                                AXI_ACLK,
  input  logic                                AXI_RESETN,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
  input  logic                                S_AXIS_TVALID,
  input  logic                                S_AXIS_TLAST,
  output logic                                S_AXIS_TREADY,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
  output logic                                M_AXIS_TVALID,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY,
  input  logic [NUM_CAUSES-1:0]               drop_array,
  input  logic [NUM_CAUSES-1:0]               drop_mask,
  input  logic                                clear_counters,
  output logic [31:0]                         dropped_count,
  output logic [31:0]                         forwarded_count
`ifdef DROP_GATE_PER_CAUSE_CNT_EN
  ,
  output logic [NUM_CAUSES*32-1:0]            cause_count
`endif
);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_decide = 2'd1;
  localparam logic [1:0] c_fwd    = 2'd2;
  localparam logic [1:0] c_drop   = 2'd3;

  logic [1:0]                          r_state;
  logic [C_S_AXIS_DATA_WIDTH-1:0]      r_head_tdata;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    r_head_tstrb;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]     r_head_tuser;
  logic                                r_head_tlast;

  logic w_out_free;
  logic w_s_fire;
  logic w_decide;
  logic w_drop;
  logic w_load_head;
  logic w_load_body;

  assign w_out_free  = !M_AXIS_TVALID || M_AXIS_TREADY;
  assign w_s_fire    = S_AXIS_TVALID && S_AXIS_TREADY;
  assign w_decide    = (r_state == c_decide);
  // Single-beat packets carry stale cause flags, so they always pass.
  assign w_drop      = (|(drop_array & drop_mask)) && !r_head_tlast;
  assign w_load_head = w_decide && !w_drop;
  assign w_load_body = (r_state == c_fwd) && w_s_fire;

  always_comb begin
    S_AXIS_TREADY = 1'b0;
    case (r_state)
      c_idle:   S_AXIS_TREADY = w_out_free;
      c_decide: S_AXIS_TREADY = 1'b0;
      c_fwd:    S_AXIS_TREADY = w_out_free;
      c_drop:   S_AXIS_TREADY = 1'b1;
      default:  S_AXIS_TREADY = 1'b0;
    endcase
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      r_state      <= c_idle;
      r_head_tdata <= '0;
      r_head_tstrb <= '0;
      r_head_tuser <= '0;
      r_head_tlast <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_s_fire) begin
            r_head_tdata <= S_AXIS_TDATA;
            r_head_tstrb <= S_AXIS_TSTRB;
            r_head_tuser <= S_AXIS_TUSER;
            r_head_tlast <= S_AXIS_TLAST;
            r_state      <= c_decide;
          end
        end
        c_decide: begin
          if (w_drop)            r_state <= c_drop;
          else if (r_head_tlast) r_state <= c_idle;
          else                   r_state <= c_fwd;
        end
        c_fwd, c_drop: begin
          if (w_s_fire && S_AXIS_TLAST) r_state <= c_idle;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  // IDLE only takes a head when the output register drains, so DECIDE can always load it.
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TSTRB  <= '0;
      M_AXIS_TUSER  <= '0;
      M_AXIS_TLAST  <= 1'b0;
    end else if (w_load_head) begin
      M_AXIS_TVALID <= 1'b1;
      M_AXIS_TDATA  <= r_head_tdata;
      M_AXIS_TSTRB  <= r_head_tstrb;
      M_AXIS_TUSER  <= r_head_tuser;
      M_AXIS_TLAST  <= r_head_tlast;
    end else if (w_load_body) begin
      M_AXIS_TVALID <= 1'b1;
      M_AXIS_TDATA  <= S_AXIS_TDATA;
      M_AXIS_TSTRB  <= S_AXIS_TSTRB;
      M_AXIS_TUSER  <= S_AXIS_TUSER;
      M_AXIS_TLAST  <= S_AXIS_TLAST;
    end else if (M_AXIS_TREADY) begin
      M_AXIS_TVALID <= 1'b0;
    end
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      dropped_count   <= '0;
      forwarded_count <= '0;
    end else if (clear_counters) begin
      dropped_count   <= '0;
      forwarded_count <= '0;
    end else begin
      if (w_load_head)          forwarded_count <= forwarded_count + 32'd1;
      if (w_decide && w_drop)   dropped_count   <= dropped_count + 32'd1;
    end
  end

`ifdef DROP_GATE_PER_CAUSE_CNT_EN
  genvar gi;
  for (gi = 0; gi < NUM_CAUSES; gi++) begin : g_cause_cnt
    logic [31:0] r_cnt;
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
      if (!AXI_RESETN)
        r_cnt <= '0;
      else if (clear_counters)
        r_cnt <= '0;
      else if (w_decide && w_drop && drop_array[gi] && drop_mask[gi])
        r_cnt <= r_cnt + 32'd1;
    end
    assign cause_count[gi*32 +: 32] = r_cnt;
  end
`endif

endmodule
`default_nettype wire
